// File: rtl/aes_result_serializer.sv
// rtl/aes_result_serializer.sv - capture, buffer and serialize AES pipeline results
//
// Sits after an unrolled AES-128 pipeline. That pipeline has no valid signal
// and cannot stall, so this block keeps its own record of which slots carry
// real blocks. It captures each finished 128-bit block into a small FIFO and
// emits the blocks as four 32-bit words, most significant word first, on a
// valid/ready stream.
//
// Parameters:
//   LATENCY  cycles from the pipeline sampling data_in to the matching data_out (>= 1)
//   DEPTH    FIFO capacity in 128-bit blocks (power of two, >= 2)
//
// Ports:
//   clk        rising-edge clock, shared with the AES pipeline
//   rst        synchronous active-high reset
//   in_valid   a real block is presented to the pipeline this cycle
//   aes_data   pipeline data_out
//   issue_ok   upstream may assert in_valid (FIFO + in-flight blocks < DEPTH)
//   out_data   current output word
//   out_valid  out_data is valid
//   out_ready  consumer accepts the word
//   out_last   current word is word 3 of its block
//   overflow   sticky; an arriving block was dropped
//   level      number of blocks held in the FIFO

module aes_result_serializer #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [127:0]                 aes_data,
    output logic                         issue_ok,
    output logic [31:0]                  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(LATENCY + 1);
    localparam int PW = $clog2(DEPTH);
    // Wide enough to hold level + inflight without wrapping.
    localparam int SW = (IW > LW) ? IW + 1 : LW + 1;

    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [IW-1:0] INF_ONE    = IW'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [SW-1:0] CREDIT_MAX = SW'(DEPTH);

    // ------------------------------------------------------------------
    // Valid tracking: a copy of in_valid travelling beside the pipeline.
    // ------------------------------------------------------------------
    logic [LATENCY-1:0] sr;
    logic [IW-1:0]      inflight;
    logic               tap;

    assign tap = sr[LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    // inflight mirrors the popcount of sr; kept as a counter so issue_ok
    // does not need an adder tree across the whole shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({in_valid, tap})
                2'b10:   inflight <= inflight + INF_ONE;
                2'b01:   inflight <= inflight - INF_ONE;
                default: inflight <= inflight;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO and serializer control
    // ------------------------------------------------------------------
    logic [127:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    idx;
    logic          full;
    logic          accept;
    logic          pop;
    logic          wr;
    logic          drop;

    assign full   = (level == LEVEL_FULL);
    assign accept = out_valid & out_ready;
    assign pop    = accept & (idx == 2'd3);
    // A full FIFO can still take the arriving block when the head leaves in
    // the same cycle: the write lands in the slot being vacated.
    assign wr     = tap & (~full | pop);
    assign drop   = tap & full & ~pop;

    always_ff @(posedge clk) begin
        if (!rst && wr) begin
            mem[wr_ptr] <= aes_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
        end else begin
            case ({wr, pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

    // idx wraps naturally from 3 to 0 on the accepting cycle that pops.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= 2'd0;
        end else if (accept) begin
            idx <= idx + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output stream
    // ------------------------------------------------------------------
    logic [127:0] head;

    assign head      = mem[rd_ptr];
    assign out_valid = (level != '0);
    assign out_last  = out_valid & (idx == 2'd3);

    always_comb begin
        out_data = head[127:96];
        case (idx)
            2'd0:    out_data = head[127:96];
            2'd1:    out_data = head[95:64];
            2'd2:    out_data = head[63:32];
            default: out_data = head[31:0];
        endcase
    end

    // Credit: uses registered counts only, so a pop in this cycle frees
    // credit from the next cycle onward.
    logic [SW-1:0] committed;

    assign committed = SW'(level) + SW'(inflight);
    assign issue_ok  = (committed < CREDIT_MAX);

endmodule
